// File: rtl/axi_soc_master.sv
// Single-outstanding AXI-style bus master: CPU load/store requests become address/data handshakes.
// Optional watchdog enabled by defining AXI_SOC_MASTER_TIMEOUT_EN (reports cpu_err on expiry).
module axi_soc_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              read_addr_valid,
  output logic              write_addr_valid,
  output logic              write_data_valid,
  output logic              read_data_ready,
  input  logic              read_addr_ready,
  input  logic              write_addr_ready,
  input  logic              write_data_ready,
  input  logic              read_data_valid,
  input  logic [DATA_W-1:0] read_data
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs, ar_hs, r_hs;
  logic              busy, timeout;

  assign busy             = (state == WRITE) || (state == RD_ADDR) || (state == RD_DATA);
  assign write_addr_valid = (state == WRITE) && !aw_done;
  assign write_data_valid = (state == WRITE) && !w_done;
  assign read_addr_valid  = (state == RD_ADDR);
  assign read_data_ready  = (state == RD_DATA);
  assign cpu_ready        = (state == IDLE);
  assign cpu_done         = (state == DONE);

  assign aw_hs = write_addr_valid && write_addr_ready;
  assign w_hs  = write_data_valid && write_data_ready;
  assign ar_hs = read_addr_valid && read_addr_ready;
  assign r_hs  = read_data_ready && read_data_valid;

  assign read_addr  = addr_q;
  assign write_addr = addr_q;
  assign write_data = wdata_q;
  assign cpu_rdata  = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Timeout has priority so an expiring transaction never half-completes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req) state_next = cpu_we ? WRITE : RD_ADDR;
      WRITE: begin
        if (timeout) state_next = DONE;
        else if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = DONE;
      end
      RD_ADDR: begin
        if (timeout)    state_next = DONE;
        else if (ar_hs) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (timeout)   state_next = DONE;
        else if (r_hs) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && cpu_req) begin
      addr_q  <= cpu_addr & ~ADDR_W'(3);
      wdata_q <= cpu_wdata;
    end
  end

  // Each write channel is tracked separately so the two handshakes may land in any order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != WRITE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rdata_q <= '0;
    else if (r_hs && !timeout) rdata_q <= read_data;
  end

`ifdef AXI_SOC_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  assign timeout = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cpu_err = (state == DONE) && err_q;

  // Restart the count on every state change so each bus phase gets the full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  tmo_cnt <= '0;
    else if (!busy || state != state_next)    tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err_q <= 1'b0;
    else if (busy) err_q <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign cpu_err = 1'b0;
`endif

endmodule
